// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first,
// with a start/busy/done handshake and borrow/zero/overflow flags.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] work;
    logic [IDX_W-1:0] idx;
    logic             bin;

    logic             accept;
    logic             last;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout;
    logic [WIDTH-1:0] result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = RUN;
                    accept     = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        last   = (idx == IDX_W'(WIDTH - 1));
        a_bit  = a_reg[idx];
        b_bit  = b_reg[idx];
        d_bit  = a_bit ^ b_bit ^ bin;
        bout   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);
        // Final bit is not yet in work on the last edge; splice it in for the flags.
        result = {d_bit, work[WIDTH-2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            work     <= '0;
            idx      <= '0;
            bin      <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            idx   <= '0;
            bin   <= 1'b0;
        end else if (state == RUN) begin
            work[idx] <= d_bit;
            bin       <= bout;
            if (last) begin
                idx      <= '0;
                diff     <= result;
                borrow   <= bout;
                zero     <= ~|result;
                overflow <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &
                            (result[WIDTH-1] != a_reg[WIDTH-1]);
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks of serial_subtractor (WIDTH=32): latency,
// flags, ignored mid-run start, back-to-back issue and mid-run reset.
module tb_serial_subtractor;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        borrow;
    logic        zero;
    logic        overflow;

    int checks;
    int failures;

    serial_subtractor #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
        .borrow   (borrow),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op with a single-cycle start; lat = edges from E0 through done edge, -1 on timeout.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        lat   = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        checks++;
        if ({busy, done, borrow, zero, overflow, diff} !== 37'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b borrow=%b zero=%b ovf=%b diff=%h, want all 0",
                     busy, done, borrow, zero, overflow, diff);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] va [5] = '{32'h5, 32'h3, 32'h8000_0000, 32'hDEAD_BEEF, 32'h0};
        logic [31:0] vb [5] = '{32'h3, 32'h5, 32'h1, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
        logic [31:0] vd [5] = '{32'h2, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0, 32'h1};
        logic [2:0]  vf [5] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b100}; // {borrow,zero,overflow}
        int lat;
        for (int k = 0; k < 5; k++) begin
            do_op(va[k], vb[k], lat);
            checks++;
            if (lat !== 33) begin
                failures++;
                $display("FAIL vec%0d_latency: got %0d edges, want 33", k, lat);
            end
            checks++;
            if (diff !== vd[k]) begin
                failures++;
                $display("FAIL vec%0d_diff: got %h, want %h", k, diff, vd[k]);
            end
            checks++;
            if ({borrow, zero, overflow} !== vf[k]) begin
                failures++;
                $display("FAIL vec%0d_flags: got b/z/o=%b, want %b", k, {borrow, zero, overflow}, vf[k]);
            end
        end
    endtask

    task automatic test_ignore_midrun();
        int pulses;
        @(negedge clk);
        a      = 32'd10;
        b      = 32'd4;
        start  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            start = (i == 5);
            if (i == 5) begin
                a = 32'h1234_5678;
                b = 32'h0000_0FFF;
            end
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL midrun_done_count: got %0d pulses, want 1", pulses);
        end
        checks++;
        if (diff !== 32'd6 || borrow !== 1'b0) begin
            failures++;
            $display("FAIL midrun_result: got diff=%h borrow=%b, want 00000006 0", diff, borrow);
        end
    endtask

    task automatic test_back_to_back();
        int first;
        int gap;
        @(negedge clk);
        a     = 32'd100;
        b     = 32'd1;
        start = 1'b1;
        first = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                first = i;
                break;
            end
        end
        checks++;
        if (first !== 32 || diff !== 32'd99) begin
            failures++;
            $display("FAIL b2b_first: got done_at=%0d diff=%h, want 32 00000063", first, diff);
        end
        a   = 32'd7;
        b   = 32'd9;
        gap = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start = 1'b0;
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_no_idle: got busy=%b after done, want 1", busy);
                end
            end
            if (done) begin
                gap = i;
                break;
            end
        end
        checks++;
        if (gap !== 33) begin
            failures++;
            $display("FAIL b2b_gap: got %0d cycles between done pulses, want 33", gap);
        end
        checks++;
        if (diff !== 32'hFFFF_FFFE || borrow !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: got diff=%h borrow=%b, want fffffffe 1", diff, borrow);
        end
    endtask

    task automatic test_reset_midrun();
        int pulses;
        int lat;
        @(negedge clk);
        a     = 32'hFFFF_0000;
        b     = 32'h0000_0001;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, borrow, zero, overflow, diff} !== 37'd0) begin
            failures++;
            $display("FAIL midrun_reset: got busy=%b done=%b borrow=%b zero=%b ovf=%b diff=%h, want all 0",
                     busy, done, borrow, zero, overflow, diff);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL midrun_reset_no_done: got %0d active cycles, want 0", pulses);
        end
        do_op(32'd9, 32'd9, lat);
        checks++;
        if (lat !== 33 || diff !== 32'd0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL after_reset_op: got lat=%0d diff=%h zero=%b, want 33 00000000 1", lat, diff, zero);
        end
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] wide;
        logic [34:0] exp_v;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 50 == 0) rb = ra;
            wide  = {1'b0, ra} - {1'b0, rb};
            exp_v = {wide[31:0], wide[32], (wide[31:0] == 32'd0),
                     (ra[31] != rb[31]) && (wide[31] != ra[31])};
            do_op(ra, rb, lat);
            checks++;
            if (lat !== 33 || {diff, borrow, zero, overflow} !== exp_v) begin
                failures++;
                $display("FAIL random%0d: a=%h b=%h got lat=%0d diff=%h b/z/o=%b, want 33 %h %b",
                         n, ra, rb, lat, diff, {borrow, zero, overflow}, exp_v[34:3], exp_v[2:0]);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_ignore_midrun();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
